ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter that shares the single 64-bit on-chip data RAM (14-bit word address, 8 byte enables, one-cycle synchronous read) between two requesters: port A (the xenowing core's data bus) and port B (a loader/DMA-style master). It selects one request per cycle with round-robin priority and drives the RAM directly. It returns read data to the requester that issued the read, tagged with a per-port valid strobe. It sits between the masters and the RAM instance in the top level.

## Interface
- No parameters; widths are fixed to the RAM: address 14, data 64, byte enables 8.
- clk  in  1  system clock
- reset_n  in  1  reset; one clock, synchronous, active-low
- a_req  in  1  port A request valid
- a_addr  in  14  port A word address
- a_byteena  in  8  port A byte enables (writes only)
- a_data  in  64  port A write data
- a_wren  in  1  port A request is a write (1) or read (0)
- a_ready  out  1  port A request accepted this cycle
- a_rdata  out  64  port A read data
- a_rdata_valid  out  1  a_rdata valid this cycle
- b_req, b_addr, b_byteena, b_data, b_wren, b_ready, b_rdata, b_rdata_valid: same as the port A signals, for port B
- ram_address  out  14  to RAM
- ram_byteena  out  8  to RAM
- ram_data  out  64  to RAM
- ram_wren  out  1  to RAM
- ram_q  in  64  from RAM; valid the cycle after the read address is presented

## Operation
- Handshake per port: valid/ready. The requester holds req and its payload stable until it samples ready=1 on a rising edge. Acceptance happens when req && ready at a clock edge.
- Grant is combinational within the cycle, from a_req, b_req and the priority register prio:
  - Only A requesting: A is granted.
  - Only B requesting: B is granted.
  - Both requesting: the port named by prio is granted (0 = A, 1 = B).
  - Neither requesting: no grant.
- At most one ready is high per cycle. ready is never high without the matching req.
- prio update, registered on each edge:
  - Grant to A: prio becomes 1.
  - Grant to B: prio becomes 0.
  - No grant: prio holds.
  - Result: strict alternation under continuous contention, with no starvation.
- RAM mux:
  - ram_address and ram_data come from the granted port. They come from port A when there is no grant.
  - ram_wren = granted port's wren; 0 when there is no grant.
  - ram_byteena = granted port's byteena on a write, 8'hFF on a read, 8'h00 when there is no grant.
- Read return:
  - A registered flag pair rd_pending_a/rd_pending_b is set for one cycle after an accepted read from that port.
  - x_rdata_valid = rd_pending_x.
  - a_rdata = b_rdata = ram_q, passed combinationally with no extra register. Consumers qualify with rdata_valid.
- Writes produce no response. The write is complete when the handshake happens.
- Reset (reset_n low at an edge): prio←0 and both rd_pending flags←0.
  - While reset_n is low, both readys are forced to 0 and ram_wren/ram_byteena are forced to 0.
  - A read accepted in the cycle before reset asserts has its valid suppressed if reset is low at the edge that would set it.

## Timing
- Reset values: a_ready=b_ready=0, a_rdata_valid=b_rdata_valid=0, ram_wren=0, ram_byteena=0, prio=0 (A wins the first tie).
- Accept-to-RAM latency: 0 cycles. The request is on the RAM pins in the same cycle as ready.
- Read latency: data and valid arrive exactly 1 cycle after the accepting edge's cycle. If accepted in cycle T, x_rdata_valid=1 in cycle T+1.
- Throughput: 1 access per cycle total.
  - A lone requester gets back-to-back grants every cycle.
  - Under contention each port gets every other cycle.
- Back-to-back reads from different ports (A in T, B in T+1): a_rdata_valid in T+1 and b_rdata_valid in T+2. The valids never overlap.
- Read-after-write to the same address on consecutive cycles returns the new data. This relies on the RAM's write-then-read ordering, and the arbiter adds no hazard logic.
- ready depends combinationally on req. A requester must not make req depend combinationally on ready.

## Test plan
- Single read: preload word 0x0010=64'h0123_4567_89AB_CDEF. a_req read @0x0010 → a_ready=1 same cycle, a_rdata_valid=1 next cycle with that value, b_rdata_valid stays 0.
- Contention: a_req and b_req held for 6 reads after reset → grant order A,B,A,B,A,B; each rdata_valid arrives 1 cycle after its grant, never both high together.
- Byte write: write 64'hFFFF_FFFF_FFFF_FFFF with byteena 8'h0F to 0x0020 (pre-zeroed), then read → 64'h0000_0000_FFFF_FFFF; ram_byteena=8'hFF during the read.
- Lone streamer: b_req high for 8 consecutive cycles, a idle → b_ready high all 8 cycles, 8 b_rdata_valid pulses in cycles 2-9; prio=0 afterwards.
- Reset mid-read: A read accepted in cycle T, reset_n low at edge T+1 → a_rdata_valid stays 0, readys 0 during reset, first post-reset tie goes to A.
- Idle: no requests for 10 cycles → ram_wren=0, ram_byteena=0, both valids 0, prio unchanged.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares the single-port 64-bit data RAM between two masters. Port A is
//   the core data bus and port B is a loader/DMA master. At most one
//   request is granted per cycle, using round-robin priority on ties. The
//   granted request drives the RAM pins in the same cycle. Read data comes
//   back one cycle later and is tagged with a per-port valid strobe.
//
// Ports
//   clk, reset_n                : clock, synchronous active-low reset
//   {a,b}_req/addr/byteena/data/wren : request channel (valid/ready)
//   {a,b}_ready                 : request accepted this cycle (combinational)
//   {a,b}_rdata, {a,b}_rdata_valid   : read return (rdata = ram_q, unregistered)
//   ram_address/byteena/data/wren    : to RAM
//   ram_q                       : from RAM, valid one cycle after the address

module ram_arbiter (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        a_req,
    input  logic [13:0] a_addr,
    input  logic [7:0]  a_byteena,
    input  logic [63:0] a_data,
    input  logic        a_wren,
    output logic        a_ready,
    output logic [63:0] a_rdata,
    output logic        a_rdata_valid,

    input  logic        b_req,
    input  logic [13:0] b_addr,
    input  logic [7:0]  b_byteena,
    input  logic [63:0] b_data,
    input  logic        b_wren,
    output logic        b_ready,
    output logic [63:0] b_rdata,
    output logic        b_rdata_valid,

    output logic [13:0] ram_address,
    output logic [7:0]  ram_byteena,
    output logic [63:0] ram_data,
    output logic        ram_wren,
    input  logic [63:0] ram_q
);

    // r_prio names the port that wins a tie: 0 = A, 1 = B.
    logic r_prio;
    logic r_rd_pending_a;
    logic r_rd_pending_b;

    logic w_grant_a;
    logic w_grant_b;

    // Grant decode. Reset masks both grants, so no request is accepted and
    // no write reaches the RAM while reset_n is low.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (reset_n) begin
            if (a_req && (!b_req || !r_prio))
                w_grant_a = 1'b1;
            else if (b_req)
                w_grant_b = 1'b1;
        end
    end

    // RAM mux. The address and data follow port A unless B holds the grant.
    // Reads enable all bytes, and an idle cycle enables none.
    always_comb begin
        ram_address = w_grant_b ? b_addr : a_addr;
        ram_data    = w_grant_b ? b_data : a_data;
        ram_wren    = 1'b0;
        ram_byteena = 8'h00;
        if (w_grant_a) begin
            ram_wren    = a_wren;
            ram_byteena = a_wren ? a_byteena : 8'hFF;
        end else if (w_grant_b) begin
            ram_wren    = b_wren;
            ram_byteena = b_wren ? b_byteena : 8'hFF;
        end
    end

    // Priority flips away from whoever was just served. The pending flags
    // mark the cycle in which ram_q carries that port's read data. When
    // reset is low at the setting edge, the flags stay clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prio         <= 1'b0;
            r_rd_pending_a <= 1'b0;
            r_rd_pending_b <= 1'b0;
        end else begin
            if (w_grant_a)
                r_prio <= 1'b1;
            else if (w_grant_b)
                r_prio <= 1'b0;
            r_rd_pending_a <= w_grant_a && !a_wren;
            r_rd_pending_b <= w_grant_b && !b_wren;
        end
    end

    assign a_ready       = w_grant_a;
    assign b_ready       = w_grant_b;
    assign a_rdata_valid = r_rd_pending_a;
    assign b_rdata_valid = r_rd_pending_b;
    assign a_rdata       = ram_q;
    assign b_rdata       = ram_q;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_req, a_wren, b_req, b_wren;
    logic [13:0] a_addr, b_addr;
    logic [7:0]  a_byteena, b_byteena;
    logic [63:0] a_data, b_data;
    logic        a_ready, b_ready, a_rdata_valid, b_rdata_valid;
    logic [63:0] a_rdata, b_rdata;
    logic [13:0] ram_address;
    logic [7:0]  ram_byteena;
    logic [63:0] ram_data;
    logic        ram_wren;
    logic [63:0] ram_q = 64'd0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_addr(a_addr), .a_byteena(a_byteena), .a_data(a_data),
        .a_wren(a_wren), .a_ready(a_ready), .a_rdata(a_rdata), .a_rdata_valid(a_rdata_valid),
        .b_req(b_req), .b_addr(b_addr), .b_byteena(b_byteena), .b_data(b_data),
        .b_wren(b_wren), .b_ready(b_ready), .b_rdata(b_rdata), .b_rdata_valid(b_rdata_valid),
        .ram_address(ram_address), .ram_byteena(ram_byteena), .ram_data(ram_data),
        .ram_wren(ram_wren), .ram_q(ram_q)
    );

    // Behavioural RAM: byte-masked write, then registered read of the same
    // address's (possibly new) contents.
    logic [63:0] mem [0:16383];
    always @(posedge clk) begin
        logic [63:0] w;
        w = mem[ram_address];
        if (ram_wren)
            for (int k = 0; k < 8; k++)
                if (ram_byteena[k]) w[k*8 +: 8] = ram_data[k*8 +: 8];
        mem[ram_address] <= w;
        ram_q <= w;
    end

    localparam logic [63:0] D10 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D30 = 64'h3030_3030_A5A5_0001;
    localparam logic [63:0] D31 = 64'h3131_3131_5A5A_0002;
    localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic        rst_n;
        logic        a_req, a_wren;
        logic [13:0] a_addr;
        logic [7:0]  a_be;
        logic [63:0] a_data;
        logic        b_req;
        logic [13:0] b_addr;
        logic        e_ar, e_br, e_av, e_bv, e_wren;
        logic [7:0]  e_be;
        logic [63:0] e_q;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_n, input logic ar, input logic aw, input logic [13:0] aa,
                       input logic [7:0] abe, input logic [63:0] ad, input logic br,
                       input logic [13:0] ba, input logic ear, input logic ebr,
                       input logic eav, input logic ebv, input logic ew,
                       input logic [7:0] ebe, input logic [63:0] eq);
        vec_t v;
        v.rst_n = rst_n; v.a_req = ar; v.a_wren = aw; v.a_addr = aa; v.a_be = abe;
        v.a_data = ad; v.b_req = br; v.b_addr = ba; v.e_ar = ear; v.e_br = ebr;
        v.e_av = eav; v.e_bv = ebv; v.e_wren = ew; v.e_be = ebe; v.e_q = eq;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        a_req = 1'b0; a_wren = 1'b0; a_addr = 14'h0; a_byteena = 8'h00; a_data = 64'h0;
        b_req = 1'b0; b_wren = 1'b0; b_addr = 14'h0;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 64'd0;
        mem[14'h010] = D10;
        mem[14'h030] = D30;
        mem[14'h031] = D31;
        reset_n = 1'b0;
        b_byteena = 8'h00; b_data = 64'h0;
        idle_inputs();

        //   rst ar aw a_addr   be     data  br b_addr   ar br av bv w  be     q
        // reset state, requests present but masked
        add(0, 1, 0, 14'h010, 8'h00, 0,   1, 14'h031, 0, 0, 0, 0, 0, 8'h00, 0);
        add(0, 0, 0, 14'h000, 8'h00, 0,   0, 14'h000, 0, 0, 0, 0, 0, 8'h00, 0);
        // contention after reset: A,B,A,B,A,B
        add(1, 1, 0, 14'h030, 8'h00, 0,   1, 14'h031, 1, 0, 0, 0, 0, 8'hFF, 0);
        add(1, 1, 0, 14'h030, 8'h00, 0,   1, 14'h031, 0, 1, 1, 0, 0, 8'hFF, D30);
        add(1, 1, 0, 14'h030, 8'h00, 0,   1, 14'h031, 1, 0, 0, 1, 0, 8'hFF, D31);
        add(1, 1, 0, 14'h030, 8'h00, 0,   1, 14'h031, 0, 1, 1, 0, 0, 8'hFF, D30);
        add(1, 1, 0, 14'h030, 8'h00, 0,   1, 14'h031, 1, 0, 0, 1, 0, 8'hFF, D31);
        add(1, 1, 0, 14'h030, 8'h00, 0,   1, 14'h031, 0, 1, 1, 0, 0, 8'hFF, D30);
        add(1, 0, 0, 14'h000, 8'h00, 0,   0, 14'h000, 0, 0, 0, 1, 0, 8'h00, D31);
        // single read of the preloaded word
        add(1, 1, 0, 14'h010, 8'h00, 0,   0, 14'h000, 1, 0, 0, 0, 0, 8'hFF, 0);
        add(1, 0, 0, 14'h000, 8'h00, 0,   0, 14'h000, 0, 0, 1, 0, 0, 8'h00, D10);
        // byte write then read-after-write
        add(1, 1, 1, 14'h020, 8'h0F, ALL, 0, 14'h000, 1, 0, 0, 0, 1, 8'h0F, 0);
        add(1, 1, 0, 14'h020, 8'h00, 0,   0, 14'h000, 1, 0, 0, 0, 0, 8'hFF, 0);
        add(1, 0, 0, 14'h000, 8'h00, 0,   0, 14'h000, 0, 0, 1, 0, 0, 8'h00, 64'h0000_0000_FFFF_FFFF);
        // lone B streamer for 8 cycles
        for (int i = 0; i < 8; i++)
            add(1, 0, 0, 14'h000, 8'h00, 0, 1, 14'h031, 0, 1, 0, i > 0, 0, 8'hFF, (i > 0) ? D31 : 64'd0);
        add(1, 0, 0, 14'h000, 8'h00, 0,   0, 14'h000, 0, 0, 0, 1, 0, 8'h00, D31);
        // tie after the streamer: priority is back at A
        add(1, 1, 0, 14'h010, 8'h00, 0,   1, 14'h031, 1, 0, 0, 0, 0, 8'hFF, 0);
        add(1, 0, 0, 14'h000, 8'h00, 0,   0, 14'h000, 0, 0, 1, 0, 0, 8'h00, D10);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset_n = vecs[i].rst_n;
            a_req = vecs[i].a_req; a_wren = vecs[i].a_wren; a_addr = vecs[i].a_addr;
            a_byteena = vecs[i].a_be; a_data = vecs[i].a_data;
            b_req = vecs[i].b_req; b_wren = 1'b0; b_addr = vecs[i].b_addr;
            #1;
            chk($sformatf("v%0d a_ready", i), a_ready, vecs[i].e_ar);
            chk($sformatf("v%0d b_ready", i), b_ready, vecs[i].e_br);
            chk($sformatf("v%0d a_valid", i), a_rdata_valid, vecs[i].e_av);
            chk($sformatf("v%0d b_valid", i), b_rdata_valid, vecs[i].e_bv);
            chk($sformatf("v%0d ram_wren", i), ram_wren, vecs[i].e_wren);
            chk($sformatf("v%0d ram_byteena", i), ram_byteena, vecs[i].e_be);
            if (vecs[i].e_av) chk($sformatf("v%0d a_rdata", i), a_rdata, vecs[i].e_q);
            if (vecs[i].e_bv) chk($sformatf("v%0d b_rdata", i), b_rdata, vecs[i].e_q);
        end

        // Reset lands on the edge that would flag an accepted A read.
        // The priority is now B, so the later tie also checks that reset restored it to A.
        @(negedge clk);
        idle_inputs(); a_req = 1'b1; a_addr = 14'h010;
        #1 chk("rst a_ready before", a_ready, 1'b1);
        #2 reset_n = 1'b0;
        #1 chk("rst a_ready forced", a_ready, 1'b0);
        @(negedge clk);
        b_req = 1'b1; b_addr = 14'h031;
        #1;
        chk("rst a_valid suppressed", a_rdata_valid, 1'b0);
        chk("rst b_ready", b_ready, 1'b0);
        chk("rst ram_wren", ram_wren, 1'b0);
        chk("rst ram_byteena", ram_byteena, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post-rst tie a_ready", a_ready, 1'b1);
        chk("post-rst tie b_ready", b_ready, 1'b0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("post-rst a_valid", a_rdata_valid, 1'b1);
        chk("post-rst a_rdata", a_rdata, D10);

        // Ten idle cycles. The priority must stay at B after the last A grant.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("idle%0d wren", i), ram_wren, 1'b0);
            chk($sformatf("idle%0d byteena", i), ram_byteena, 8'h00);
            chk($sformatf("idle%0d valids", i), {a_rdata_valid, b_rdata_valid}, 2'b00);
        end
        @(negedge clk);
        a_req = 1'b1; a_addr = 14'h010; b_req = 1'b1; b_addr = 14'h031;
        #1;
        chk("idle tie a_ready", a_ready, 1'b0);
        chk("idle tie b_ready", b_ready, 1'b1);
        chk("idle tie ram_address", ram_address, 14'h031);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("idle tie b_valid", b_rdata_valid, 1'b1);
        chk("idle tie a_valid", a_rdata_valid, 1'b0);
        chk("idle tie b_rdata", b_rdata, D31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Valids from the two ports must never overlap.
    always @(negedge clk) begin
        if (a_rdata_valid && b_rdata_valid) begin
            total++;
            bad++;
            $display("FAIL valid overlap: a=%b b=%b want not both", a_rdata_valid, b_rdata_valid);
        end
    end

endmodule
